// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register: captures execute-stage results for the memory stage,
// with flush/stall handling, register-0 write squashing and saturating perf counters.
module ex_mem_register #(
    parameter int CNT_W             = 16,
    parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             ValidIn,
    input  logic             BranchIn,
    input  logic             MemReadIn,
    input  logic             MemWriteIn,
    input  logic             RegWriteIn,
    input  logic             MemToRegIn,
    input  logic [31:0]      BranchTargetAddressIn,
    input  logic [31:0]      ALUIn,
    input  logic [31:0]      MemoryWriteDataIn,
    input  logic             ZeroIn,
    input  logic [4:0]       DestinationRegIn,
    output logic             ValidOut,
    output logic             BranchOut,
    output logic             MemReadOut,
    output logic             MemWriteOut,
    output logic             RegWriteOut,
    output logic             MemToRegOut,
    output logic             ZeroOut,
    output logic [31:0]      BranchTargetAddressOut,
    output logic [31:0]      ALUOut,
    output logic [31:0]      MemoryWriteDataOut,
    output logic [4:0]       DestinationRegOut,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] RetireCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic        valid_r,     validNext_s;
    logic        branch_r,    branchNext_s;
    logic        memRead_r,   memReadNext_s;
    logic        memWrite_r,  memWriteNext_s;
    logic        regWrite_r,  regWriteNext_s;
    logic        memToReg_r,  memToRegNext_s;
    logic        zero_r,      zeroNext_s;
    logic [31:0] target_r,    targetNext_s;
    logic [31:0] aluData_r,   aluDataNext_s;
    logic [31:0] storeData_r, storeDataNext_s;
    logic [4:0]  destReg_r,   destRegNext_s;

    logic [CNT_W-1:0] stallCount_r;
    logic [CNT_W-1:0] retireCount_r;

    logic loadEdge_s;
    logic destWritable_s;
    logic stallInc_s;
    logic retireInc_s;

    // Edge classification shared by the datapath and the counters.
    always_comb begin
        loadEdge_s     = 1'b0;
        destWritable_s = 1'b1;
        stallInc_s     = 1'b0;
        retireInc_s    = 1'b0;
        if (!Flush && !Stall) begin
            loadEdge_s = 1'b1;
        end else begin
            loadEdge_s = 1'b0;
        end
        if (ZERO_REG_SUPPRESS && (DestinationRegIn == 5'd0)) begin
            destWritable_s = 1'b0;
        end else begin
            destWritable_s = 1'b1;
        end
        if (!Flush && Stall) begin
            stallInc_s = 1'b1;
        end else begin
            stallInc_s = 1'b0;
        end
        if (loadEdge_s && ValidIn) begin
            retireInc_s = 1'b1;
        end else begin
            retireInc_s = 1'b0;
        end
    end

    // Next-state selection with priority Flush > Stall > Load.
    always_comb begin
        validNext_s     = valid_r;
        branchNext_s    = branch_r;
        memReadNext_s   = memRead_r;
        memWriteNext_s  = memWrite_r;
        regWriteNext_s  = regWrite_r;
        memToRegNext_s  = memToReg_r;
        zeroNext_s      = zero_r;
        targetNext_s    = target_r;
        aluDataNext_s   = aluData_r;
        storeDataNext_s = storeData_r;
        destRegNext_s   = destReg_r;
        if (Flush) begin
            validNext_s     = 1'b0;
            branchNext_s    = 1'b0;
            memReadNext_s   = 1'b0;
            memWriteNext_s  = 1'b0;
            regWriteNext_s  = 1'b0;
            memToRegNext_s  = 1'b0;
            zeroNext_s      = 1'b0;
            targetNext_s    = 32'd0;
            aluDataNext_s   = 32'd0;
            storeDataNext_s = 32'd0;
            destRegNext_s   = 5'd0;
        end else if (Stall) begin
            validNext_s     = valid_r;
            branchNext_s    = branch_r;
            memReadNext_s   = memRead_r;
            memWriteNext_s  = memWrite_r;
            regWriteNext_s  = regWrite_r;
            memToRegNext_s  = memToReg_r;
            zeroNext_s      = zero_r;
            targetNext_s    = target_r;
            aluDataNext_s   = aluData_r;
            storeDataNext_s = storeData_r;
            destRegNext_s   = destReg_r;
        end else begin
            // Data fields load even for bubbles; only control bits are gated.
            validNext_s     = ValidIn;
            branchNext_s    = ValidIn & BranchIn;
            memReadNext_s   = ValidIn & MemReadIn;
            memWriteNext_s  = ValidIn & MemWriteIn;
            regWriteNext_s  = ValidIn & RegWriteIn & destWritable_s;
            memToRegNext_s  = ValidIn & MemToRegIn & destWritable_s;
            zeroNext_s      = ZeroIn;
            targetNext_s    = BranchTargetAddressIn;
            aluDataNext_s   = ALUIn;
            storeDataNext_s = MemoryWriteDataIn;
            destRegNext_s   = DestinationRegIn;
        end
    end

    // Pipeline register state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_r     <= 1'b0;
            branch_r    <= 1'b0;
            memRead_r   <= 1'b0;
            memWrite_r  <= 1'b0;
            regWrite_r  <= 1'b0;
            memToReg_r  <= 1'b0;
            zero_r      <= 1'b0;
            target_r    <= 32'd0;
            aluData_r   <= 32'd0;
            storeData_r <= 32'd0;
            destReg_r   <= 5'd0;
        end else begin
            valid_r     <= validNext_s;
            branch_r    <= branchNext_s;
            memRead_r   <= memReadNext_s;
            memWrite_r  <= memWriteNext_s;
            regWrite_r  <= regWriteNext_s;
            memToReg_r  <= memToRegNext_s;
            zero_r      <= zeroNext_s;
            target_r    <= targetNext_s;
            aluData_r   <= aluDataNext_s;
            storeData_r <= storeDataNext_s;
            destReg_r   <= destRegNext_s;
        end
    end

    // Saturating stall counter; flush edges leave it untouched.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stallCount_r <= {CNT_W{1'b0}};
        end else if (stallInc_s && (stallCount_r != CNT_MAX)) begin
            stallCount_r <= stallCount_r + CNT_ONE;
        end else begin
            stallCount_r <= stallCount_r;
        end
    end

    // Saturating retire counter for valid instructions captured on load edges.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            retireCount_r <= {CNT_W{1'b0}};
        end else if (retireInc_s && (retireCount_r != CNT_MAX)) begin
            retireCount_r <= retireCount_r + CNT_ONE;
        end else begin
            retireCount_r <= retireCount_r;
        end
    end

    assign ValidOut               = valid_r;
    assign BranchOut              = branch_r;
    assign MemReadOut             = memRead_r;
    assign MemWriteOut            = memWrite_r;
    assign RegWriteOut            = regWrite_r;
    assign MemToRegOut            = memToReg_r;
    assign ZeroOut                = zero_r;
    assign BranchTargetAddressOut = target_r;
    assign ALUOut                 = aluData_r;
    assign MemoryWriteDataOut     = storeData_r;
    assign DestinationRegOut      = destReg_r;
    assign StallCount             = stallCount_r;
    assign RetireCount            = retireCount_r;

endmodule
